// File: rtl/gate_truth_table_checker.sv
// rtl/gate_truth_table_checker.sv - drives a 2-input gate through all four input
// combinations and checks each settled result against an expected truth table.
module gate_truth_table_checker #(
    parameter logic [3:0] TRUTH_TABLE   = 4'b1000,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    output logic       drive1,
    output logic       drive2,
    input  logic       sample,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] error_count,
    output logic [3:0] fail_vector
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic [1:0] r_idx;
    logic [3:0] r_cnt;
    logic       r_drive1;
    logic       r_drive2;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [2:0] r_err;
    logic [3:0] r_fv;

    state_t     w_next_state;
    logic [1:0] w_next_idx;
    logic [3:0] w_next_cnt;
    logic       w_next_pass;
    logic [2:0] w_next_err;
    logic [3:0] w_next_fv;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_next_cnt   = r_cnt;
        w_next_pass  = r_pass;
        w_next_err   = r_err;
        w_next_fv    = r_fv;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = SETTLE;
                    w_next_idx   = 2'd0;
                    w_next_cnt   = 4'd0;
                    w_next_pass  = 1'b0;
                    w_next_err   = 3'd0;
                    w_next_fv    = 4'd0;
                end
            end
            SETTLE: begin
                if (r_cnt == LAST_CNT) begin
                    w_next_cnt = 4'd0;
                    if (sample != TRUTH_TABLE[r_idx]) begin
                        w_next_fv[r_idx] = 1'b1;
                        if (r_err != 3'd4) begin
                            w_next_err = r_err + 3'd1;
                        end
                    end
                    if (r_idx == 2'd3) begin
                        w_next_state = DONE;
                        w_next_pass  = (w_next_err == 3'd0);
                    end else begin
                        w_next_idx = r_idx + 2'd1;
                    end
                end else begin
                    w_next_cnt = r_cnt + 4'd1;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so drives move on the same edge as idx.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx    <= 2'd0;
            r_cnt    <= 4'd0;
            r_drive1 <= 1'b0;
            r_drive2 <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= 3'd0;
            r_fv     <= 4'd0;
        end else begin
            r_idx    <= w_next_idx;
            r_cnt    <= w_next_cnt;
            r_busy   <= (w_next_state == SETTLE);
            r_drive1 <= (w_next_state == SETTLE) && w_next_idx[0];
            r_drive2 <= (w_next_state == SETTLE) && w_next_idx[1];
            r_done   <= (w_next_state == DONE);
            r_pass   <= w_next_pass;
            r_err    <= w_next_err;
            r_fv     <= w_next_fv;
        end
    end

    assign drive1      = r_drive1;
    assign drive2      = r_drive2;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign error_count = r_err;
    assign fail_vector = r_fv;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// tb/tb_gate_truth_table_checker.sv - self-checking bench for gate_truth_table_checker.
module tb_gate_truth_table_checker;

    logic       clock;
    logic       reset_n;
    logic       start_a, start_b, stuck;
    logic       drive1_a, drive2_a, sample_a, busy_a, done_a, pass_a;
    logic [2:0] ec_a;
    logic [3:0] fv_a;
    logic       drive1_b, drive2_b, sample_b, busy_b, done_b, pass_b;
    logic [2:0] ec_b;
    logic [3:0] fv_b;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int         phase;
        int         err;
        logic [3:0] fv;
        logic       pass;
    } model_t;

    model_t ma = '{phase: 0, err: 0, fv: 4'b0, pass: 1'b0};
    model_t mb = '{phase: 0, err: 0, fv: 4'b0, pass: 1'b0};

    gate_truth_table_checker u_dut_and (
        .clock(clock), .reset_n(reset_n), .start(start_a),
        .drive1(drive1_a), .drive2(drive2_a), .sample(sample_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .error_count(ec_a), .fail_vector(fv_a)
    );

    gate_truth_table_checker #(.TRUTH_TABLE(4'b1110), .SETTLE_CYCLES(1)) u_dut_or (
        .clock(clock), .reset_n(reset_n), .start(start_b),
        .drive1(drive1_b), .drive2(drive2_b), .sample(sample_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .error_count(ec_b), .fail_vector(fv_b)
    );

    // Gate under test: an AND gate, optionally with its output stuck at 1.
    assign sample_a = stuck ? 1'b1 : (drive1_a & drive2_a);
    assign sample_b = drive1_b & drive2_b;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // phase = cycles since the accepting edge; 0 means idle.
    function automatic model_t step(model_t m, logic st, int s, logic [3:0] tt, logic [3:0] gt);
        model_t n = m;
        int k;
        if (m.phase == 0) begin
            if (st) begin
                n.phase = 1; n.err = 0; n.fv = 4'b0; n.pass = 1'b0;
            end
        end else if (m.phase <= 4 * s) begin
            k = (m.phase - 1) / s;
            if ((m.phase % s) == 0 && gt[k] != tt[k]) begin
                n.fv[k] = 1'b1;
                n.err = (m.err < 4) ? m.err + 1 : 4;
            end
            n.phase = m.phase + 1;
            if (n.phase == 4 * s + 1) n.pass = (n.err == 0);
        end else begin
            n.phase = 0;
        end
        return n;
    endfunction

    function automatic logic [11:0] expect_vec(model_t m, int s);
        logic b;
        int   k;
        b = (m.phase >= 1) && (m.phase <= 4 * s);
        k = b ? (m.phase - 1) / s : 0;
        return {b, (m.phase == 4 * s + 1), b & k[0], b & k[1], m.pass, 3'(m.err), m.fv};
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ma = '{phase: 0, err: 0, fv: 4'b0, pass: 1'b0};
            mb = '{phase: 0, err: 0, fv: 4'b0, pass: 1'b0};
        end else begin
            ma = step(ma, start_a, 2, 4'b1000, stuck ? 4'b1111 : 4'b1000);
            mb = step(mb, start_b, 1, 4'b1110, 4'b1000);
        end
    end

    always @(negedge clock) begin
        check("and_outputs", {20'b0, busy_a, done_a, drive1_a, drive2_a, pass_a, ec_a, fv_a},
              {20'b0, expect_vec(ma, 2)});
        check("or_outputs", {20'b0, busy_b, done_b, drive1_b, drive2_b, pass_b, ec_b, fv_b},
              {20'b0, expect_vec(mb, 1)});
    end

    task automatic run_timed(input bit use_b, output int done_cyc, output int busy_cyc);
        done_cyc = -1;
        busy_cyc = 0;
        @(negedge clock);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            start_a = 1'b0;
            start_b = 1'b0;
            if (use_b ? busy_b : busy_a) busy_cyc++;
            if (use_b ? done_b : done_a) begin
                done_cyc = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dc, bc, ndone;
        reset_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        stuck   = 1'b0;
        @(negedge clock);
        check("reset_outputs", {busy_a, done_a, drive1_a, drive2_a, pass_a, ec_a, fv_a}, 0);
        @(negedge clock);
        #1 reset_n = 1'b1;

        // Clean AND run
        run_timed(0, dc, bc);
        check("and_done_cycle", dc, 9);
        check("and_busy_cycles", bc, 8);
        check("and_pass", pass_a, 1);
        check("and_err_fv", {ec_a, fv_a}, {3'd0, 4'b0000});
        check("model_and_pass", ma.pass, 1);

        // Stuck-at-1 output
        stuck = 1'b1;
        run_timed(0, dc, bc);
        check("stuck_done_cycle", dc, 9);
        repeat (5) @(negedge clock);
        check("stuck_held", {pass_a, ec_a, fv_a}, {1'b0, 3'd3, 4'b0111});
        check("model_stuck", {ma.pass, 3'(ma.err), ma.fv}, {1'b0, 3'd3, 4'b0111});
        stuck = 1'b0;

        // OR truth table against an AND gate, one settle cycle
        run_timed(1, dc, bc);
        check("or_busy_cycles", bc, 4);
        check("or_done_cycle", dc, 5);
        check("or_result", {pass_b, ec_b, fv_b}, {1'b0, 3'd2, 4'b0110});

        // Restart attempts during SETTLE and DONE are ignored
        stuck = 1'b1;
        ndone = 0;
        dc = -1;
        @(negedge clock);
        start_a = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clock);
            if (done_a) begin
                ndone++;
                dc = i;
            end
            if (i == 9) stuck = 1'b0;
            if (i == 10) check("repulse_single_done", ndone, 1);
            if (i == 12) check("repulse_cleared", {ec_a, fv_a}, 0);
            start_a = (i == 3 || i == 9 || i == 11);
        end
        check("repulse_second_done", dc, 20);
        check("repulse_second_pass", pass_a, 1);

        // Asynchronous reset in the middle of the third combination
        stuck = 1'b1;
        @(negedge clock);
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        repeat (3) @(negedge clock);
        @(posedge clock);
        #1 check("pre_reset_state", {busy_a, drive1_a, drive2_a, ec_a}, {1'b1, 1'b0, 1'b1, 3'd2});
        #1 reset_n = 1'b0;
        #1 check("async_reset_outputs", {busy_a, done_a, drive1_a, drive2_a, pass_a, ec_a, fv_a}, 0);
        @(negedge clock);
        #1 reset_n = 1'b1;
        stuck = 1'b0;
        run_timed(0, dc, bc);
        check("post_reset_done_cycle", dc, 9);
        check("post_reset_pass", {pass_a, ec_a, fv_a}, {1'b1, 3'd0, 4'b0});

        // start held high: back-to-back runs every 10 cycles
        ndone = 0;
        @(negedge clock);
        start_a = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            if (done_a) ndone++;
        end
        start_a = 1'b0;
        check("held_start_done_count", ndone, 3);
        repeat (12) @(negedge clock);
        check("held_start_pass", pass_a, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
